// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: widths, breakpoint record and fuzzifier state type shared across the fuzzy datapath
package fuzzy_pkg;
  localparam int DATA_W = 10;
  localparam int DEG_W = 10;
  localparam int NUM_W = DATA_W + DEG_W;
  localparam logic [DEG_W-1:0] DEG_MAX = '1;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } bp_t;
  typedef enum logic [2:0] {IDLE, SEG, DIV, STORE, HOLD} fz_state_t;
endpackage

// File: rtl/trap_mf_fuzzifier_if.sv
// trap_mf_fuzzifier_if: sample in, breakpoint write, degree vector out
// master = producer/consumer side, slave = fuzzifier
interface trap_mf_fuzzifier_if import fuzzy_pkg::*; #(parameter int FN_NUM = 4);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic bp_wr_en;
  logic [2:0] bp_wr_idx;
  logic [4*DATA_W-1:0] bp_wr_data;
  logic bp_error;
  logic out_valid;
  logic out_ready;
  logic [FN_NUM*DEG_W-1:0] out_degree;
  modport master(output in_valid, in_data, bp_wr_en, bp_wr_idx, bp_wr_data, out_ready,
                 input in_ready, bp_error, out_valid, out_degree);
  modport slave(input in_valid, in_data, bp_wr_en, bp_wr_idx, bp_wr_data, out_ready,
                output in_ready, bp_error, out_valid, out_degree);
endinterface

// File: rtl/serial_divider.sv
// serial_divider: restoring divider, one quotient bit per cycle, Q_W cycles after start
// ports: start loads num/den; busy while stepping; done marks the final step; quot valid after done
module serial_divider #(
  parameter int NUM_W = 20,
  parameter int DEN_W = 10,
  parameter int Q_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic busy,
  output logic done,
  output logic [Q_W-1:0] quot
);
  localparam int C_W = $clog2(Q_W + 1);
  logic [DEN_W-1:0] rem, dv;
  logic [Q_W-1:0] q;
  logic [C_W-1:0] cnt;
  logic [DEN_W:0] trial;
  logic ge;
  // quotient fits Q_W bits, so the upper DEN_W numerator bits are already below den
  assign trial = {rem, q[Q_W-1]};
  assign ge = trial >= {1'b0, dv};
  assign busy = cnt != '0;
  assign done = cnt == C_W'(1);
  assign quot = q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      dv <= '0;
      q <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= num[NUM_W-1:Q_W];
      q <= num[Q_W-1:0];
      dv <= den;
      cnt <= C_W'(Q_W);
    end else if (busy) begin
      rem <= ge ? DEN_W'(trial - {1'b0, dv}) : trial[DEN_W-1:0];
      q <= {q[Q_W-2:0], ge};
      cnt <= cnt - C_W'(1);
    end
endmodule

// File: rtl/trap_mf_fuzzifier.sv
// trap_mf_fuzzifier: trapezoidal membership degrees for FN_NUM functions of one sample
// ports: clk, rst_n (async active-low), bus (slave: sample, breakpoint write, degree vector)
module trap_mf_fuzzifier import fuzzy_pkg::*; #(
  parameter int FN_NUM = 4
) (
  input logic clk,
  input logic rst_n,
  trap_mf_fuzzifier_if.slave bus
);
  localparam int K_W = FN_NUM > 1 ? $clog2(FN_NUM) : 1;
  fz_state_t state, state_n;
  bp_t bp [FN_NUM];
  bp_t cur, wr_bp;
  logic [DEG_W-1:0] acc [FN_NUM];
  logic [DATA_W-1:0] x, diff, den;
  logic [K_W-1:0] k;
  logic [NUM_W-1:0] num;
  logic [DEG_W-1:0] flat_deg, seg_deg, quot;
  logic flat, seg_flat, in_top, rise, last, wr_ok, bp_error, div_busy, div_done;
  assign cur = bp[k];
  assign wr_bp = bp_t'(bus.bp_wr_data);
  assign wr_ok = state == IDLE && int'(bus.bp_wr_idx) < FN_NUM &&
                 wr_bp.a <= wr_bp.b && wr_bp.b <= wr_bp.c && wr_bp.c <= wr_bp.d;
  assign last = k == K_W'(FN_NUM - 1);
  // plateau wins over the outer zero region, so degenerate shapes still reach DEG_MAX at b..c
  assign in_top = cur.b <= x && x <= cur.c;
  assign seg_flat = in_top || x <= cur.a || x >= cur.d;
  assign rise = x < cur.b;
  assign seg_deg = in_top ? DEG_MAX : '0;
  assign diff = rise ? x - cur.a : cur.d - x;
  // flat cases still run the divider (0/1) so every function costs the same cycles
  assign num = seg_flat ? '0 : NUM_W'(diff) * NUM_W'(DEG_MAX);
  assign den = seg_flat ? DATA_W'(1) : rise ? cur.b - cur.a : cur.d - cur.c;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == HOLD;
  assign bus.bp_error = bp_error;
  for (genvar g = 0; g < FN_NUM; g++) begin : g_out
    assign bus.out_degree[g*DEG_W +: DEG_W] = state == HOLD ? acc[g] : '0;
  end
  serial_divider #(.NUM_W(NUM_W), .DEN_W(DATA_W), .Q_W(DEG_W)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(state == SEG),
    .num(num),
    .den(den),
    .busy(div_busy),
    .done(div_done),
    .quot(quot)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.in_valid ? SEG : IDLE;
      SEG: state_n = DIV;
      DIV: state_n = div_done || !div_busy ? STORE : DIV;
      STORE: state_n = last ? HOLD : SEG;
      HOLD: state_n = bus.out_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FN_NUM; i++) begin
        bp[i] <= '0;
        acc[i] <= '0;
      end
      x <= '0;
      k <= '0;
      flat <= 1'b0;
      flat_deg <= '0;
      bp_error <= 1'b0;
    end else begin
      bp_error <= bus.bp_wr_en && !wr_ok;
      if (bus.bp_wr_en && wr_ok) bp[bus.bp_wr_idx[K_W-1:0]] <= wr_bp;
      if (state == IDLE && bus.in_valid) begin
        x <= bus.in_data;
        k <= '0;
        for (int i = 0; i < FN_NUM; i++) acc[i] <= '0;
      end
      if (state == SEG) begin
        flat <= seg_flat;
        flat_deg <= seg_deg;
      end
      if (state == STORE) begin
        acc[k] <= flat ? flat_deg : quot;
        if (!last) k <= k + K_W'(1);
      end
    end
endmodule

// File: tb/tb_trap_mf_fuzzifier.sv
// tb_trap_mf_fuzzifier: randomized and directed checks against a trapezoid reference model
module tb_trap_mf_fuzzifier;
  import fuzzy_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0, errs = 0, cyc = 0, acc_cyc = 0;
  int ma[4], mb[4], mc[4], md[4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  trap_mf_fuzzifier_if #(.FN_NUM(4)) bus();
  trap_mf_fuzzifier #(.FN_NUM(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_deg(input int i, input int x);
    if (mb[i] <= x && x <= mc[i]) return 1023;
    if (x <= ma[i] || x >= md[i]) return 0;
    if (x < mb[i]) return (x - ma[i]) * 1023 / (mb[i] - ma[i]);
    return (md[i] - x) * 1023 / (md[i] - mc[i]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      ma[i] = 0; mb[i] = 0; mc[i] = 0; md[i] = 0;
    end
  endtask

  task automatic bp_wr(input int idx, input int a, input int b, input int c, input int d, input bit idle);
    bit ok;
    ok = idle && idx < 4 && a <= b && b <= c && c <= d;
    @(negedge clk);
    bus.bp_wr_en = 1'b1;
    bus.bp_wr_idx = 3'(idx);
    bus.bp_wr_data = {10'(d), 10'(c), 10'(b), 10'(a)};
    @(posedge clk);
    #1 bus.bp_wr_en = 1'b0;
    chk($sformatf("bp_error idx=%0d (%0d,%0d,%0d,%0d)", idx, a, b, c, d), bus.bp_error, !ok);
    if (ok) begin
      ma[idx] = a; mb[idx] = b; mc[idx] = c; md[idx] = d;
    end
    @(posedge clk);
    #1 chk("bp_error_pulse_end", bus.bp_error, 0);
  endtask

  task automatic start_sample(input int x);
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data = 10'(x);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic finish_sample(input int x, input int hold);
    logic [39:0] held;
    while (!bus.out_valid && cyc - acc_cyc < 100) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("latency x=%0d", x), cyc - acc_cyc, 48);
    for (int i = 0; i < 4; i++)
      chk($sformatf("deg%0d x=%0d", i, x), bus.out_degree[i*10 +: 10], ref_deg(i, x));
    held = bus.out_degree;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = h % 2 == 0;
      bus.in_data = 10'($urandom);
      @(posedge clk);
      #1;
      chk("hold_degree_stable", bus.out_degree, held);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_out_valid", bus.out_valid, 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic sample(input int x);
    start_sample(x);
    finish_sample(x, 0);
  endtask

  initial begin
    int v[4];
    int t;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.bp_wr_en = 1'b0;
    bus.bp_wr_idx = '0;
    bus.bp_wr_data = '0;
    bus.out_ready = 1'b0;
    clear_model();
    #22;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_degree", bus.out_degree, 0);
    chk("rst_bp_error", bus.bp_error, 0);
    rst_n = 1'b1;
    sample(0);
    sample(1);
    bp_wr(0, 0, 1, 2, 3, 1);
    bp_wr(1, 2, 3, 5, 7, 1);
    bp_wr(2, 6, 8, 10, 12, 1);
    bp_wr(3, 11, 14, 16, 20, 1);
    sample(6);
    sample(13);
    sample(4);
    start_sample(13);
    finish_sample(13, 20);
    bp_wr(1, 5, 3, 7, 9, 1);
    bp_wr(5, 1, 2, 3, 4, 1);
    start_sample(6);
    repeat (4) @(posedge clk);
    bp_wr(1, 0, 0, 30, 40, 0);
    finish_sample(6, 0);
    bp_wr(0, 4, 4, 4, 4, 1);
    sample(4);
    sample(3);
    sample(5);
    bp_wr(2, 0, 0, 1023, 1023, 1);
    bp_wr(3, 0, 1023, 1023, 1023, 1);
    sample(1023);
    sample(1022);
    @(negedge clk);
    bus.bp_wr_en = 1'b1;
    bus.bp_wr_idx = 3'd0;
    bus.bp_wr_data = {10'd30, 10'd20, 10'd15, 10'd10};
    bus.in_valid = 1'b1;
    bus.in_data = 10'd12;
    @(posedge clk);
    #1 bus.bp_wr_en = 1'b0;
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    chk("same_cycle_wr_ok", bus.bp_error, 0);
    ma[0] = 10; mb[0] = 15; mc[0] = 20; md[0] = 30;
    finish_sample(12, 0);
    for (t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) v[i] = $urandom_range(0, 60);
      if (t % 4 != 3)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3 - i; j++)
            if (v[j] > v[j+1]) begin
              int s;
              s = v[j]; v[j] = v[j+1]; v[j+1] = s;
            end
      bp_wr(t % 5 == 4 ? $urandom_range(4, 7) : $urandom_range(0, 3), v[0], v[1], v[2], v[3], 1);
      sample($urandom_range(0, 64));
    end
    start_sample(20);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_degree", bus.out_degree, 0);
    chk("abort_bp_error", bus.bp_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    sample(0);
    sample(9);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
